// File: rtl/keypad_multi_display.sv
// 4x4 keypad scanner with press/release debounce, hex key history and a multiplexed seven-segment display.
// Optional build macro KEYPAD_LEADING_BLANK_EN blanks digits that hold no entered key yet.
`timescale 1ns/1ps
module keypad_multi_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 4800,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REFRESH_DIV    = 50
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [3:0]                      cols,
    output logic [3:0]                      rows,
    output logic [6:0]                      segs,
    output logic [NUM_DIGITS-1:0]           anodes,
    output logic                            new_key,
    output logic [3:0]                      key_code,
    output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(DEBOUNCE_TICKS + 1);
`ifdef KEYPAD_LEADING_BLANK_EN
    localparam logic [6:0] SEGS_RST = 7'h7F;
`else
    localparam logic [6:0] SEGS_RST = 7'b1000000;
`endif

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'd0:  key_map = 4'h1;
            4'd1:  key_map = 4'h2;
            4'd2:  key_map = 4'h3;
            4'd3:  key_map = 4'hA;
            4'd4:  key_map = 4'h4;
            4'd5:  key_map = 4'h5;
            4'd6:  key_map = 4'h6;
            4'd7:  key_map = 4'hB;
            4'd8:  key_map = 4'h7;
            4'd9:  key_map = 4'h8;
            4'd10: key_map = 4'h9;
            4'd11: key_map = 4'hC;
            4'd12: key_map = 4'hE;
            4'd13: key_map = 4'h0;
            4'd14: key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    logic [3:0]    sync1_reg, sync2_reg;
    logic [SW-1:0] scan_cnt_reg;
    logic          tick;

    assign tick = (scan_cnt_reg == SW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            scan_cnt_reg <= '0;
        end else begin
            sync1_reg    <= cols;
            sync2_reg    <= sync1_reg;
            scan_cnt_reg <= tick ? '0 : scan_cnt_reg + 1'b1;
        end
    end

    state_t        state_reg, state_next;
    logic [3:0]    rows_reg, rows_next;
    logic [1:0]    col_reg, col_next;
    logic [BW-1:0] db_reg, db_next, db_inc;
    logic [1:0]    low_col, row_idx;
    logic          col_hit;

    always_comb begin
        state_next = state_reg;
        rows_next  = rows_reg;
        col_next   = col_reg;
        db_next    = db_reg;
        new_key    = 1'b0;
        low_col    = sync2_reg[0] ? 2'd0 : sync2_reg[1] ? 2'd1 : sync2_reg[2] ? 2'd2 : 2'd3;
        row_idx    = rows_reg[1] ? 2'd1 : rows_reg[2] ? 2'd2 : rows_reg[3] ? 2'd3 : 2'd0;
        col_hit    = sync2_reg[col_reg];
        db_inc     = db_reg + 1'b1;
        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (sync2_reg == 4'b0) begin
                        rows_next = {rows_reg[2:0], rows_reg[3]};
                    end else begin
                        col_next   = low_col;
                        db_next    = '0;
                        state_next = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (col_hit) begin
                        db_next = db_inc;
                        if (db_inc == BW'(DEBOUNCE_TICKS)) begin
                            state_next = HELD;
                            new_key    = 1'b1;
                        end
                    end else begin
                        state_next = SCAN;
                    end
                end
                HELD: begin
                    if (!col_hit) begin
                        db_next    = '0;
                        state_next = REL_DB;
                    end
                end
                default: begin
                    if (!col_hit) begin
                        db_next = db_inc;
                        if (db_inc == BW'(DEBOUNCE_TICKS)) state_next = SCAN;
                    end else begin
                        state_next = HELD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= SCAN;
            rows_reg  <= 4'b0001;
            col_reg   <= '0;
            db_reg    <= '0;
        end else begin
            state_reg <= state_next;
            rows_reg  <= rows_next;
            col_reg   <= col_next;
            db_reg    <= db_next;
        end
    end

    // History: element 0 is the newest key; the oldest falls off the end on each accept.
    logic [3:0]    hist_reg  [NUM_DIGITS];
    logic [3:0]    hist_next [NUM_DIGITS];
    logic [3:0]    key_code_reg;
    logic [CW-1:0] count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_next[gi] = new_key ? key_map(row_idx, col_reg) : hist_reg[gi];
            end else begin : g_tail
                assign hist_next[gi] = new_key ? hist_reg[gi-1] : hist_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) hist_reg[i] <= '0;
            key_code_reg <= '0;
            count_reg    <= '0;
        end else begin
            hist_reg <= hist_next;
            if (new_key) begin
                key_code_reg <= key_map(row_idx, col_reg);
                if (count_reg != CW'(NUM_DIGITS)) count_reg <= count_reg + 1'b1;
            end
        end
    end

    logic [RW-1:0]         ref_cnt_reg;
    logic                  refresh;
    logic [DW-1:0]         digit_reg, digit_next;
    logic [NUM_DIGITS-1:0] anodes_reg;
    logic [6:0]            segs_reg, segs_next;

    assign refresh    = (ref_cnt_reg == RW'(REFRESH_DIV - 1));
    assign digit_next = (digit_reg == DW'(NUM_DIGITS - 1)) ? '0 : digit_reg + 1'b1;
`ifdef KEYPAD_LEADING_BLANK_EN
    assign segs_next  = (CW'(digit_next) >= count_reg) ? 7'h7F : glyph(hist_reg[digit_next]);
`else
    assign segs_next  = glyph(hist_reg[digit_next]);
`endif

    // Segments and anodes load together on the strobe, so a history shift only shows at the next step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt_reg <= '0;
            digit_reg   <= '0;
            anodes_reg  <= ~NUM_DIGITS'(1);
            segs_reg    <= SEGS_RST;
        end else begin
            ref_cnt_reg <= refresh ? '0 : ref_cnt_reg + 1'b1;
            if (refresh) begin
                digit_reg  <= digit_next;
                anodes_reg <= ~(NUM_DIGITS'(1) << digit_next);
                segs_reg   <= segs_next;
            end
        end
    end

    assign rows        = rows_reg;
    assign segs        = segs_reg;
    assign anodes      = anodes_reg;
    assign key_code    = key_code_reg;
    assign digit_count = count_reg;
endmodule
